// File: rtl/muldiv_unit_if.sv
// Handshake/data bundle between the CPU datapath and the iterative multiply/divide unit.
// The master drives operands and commands; the slave returns busy/done and the HI/LO registers.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             mthi;
    logic             mtlo;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_data, rt_data, mthi, mtlo,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, mthi, mtlo,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit: WIDTH-step shift-add multiply or restoring divide
// on magnitudes, followed by a single sign-fix cycle that commits the architectural HI/LO.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_count;
    logic                 r_isDiv;
    logic [WIDTH-1:0]     r_operand;
    logic [2*WIDTH-1:0]   r_acc;
    logic                 r_negLo;
    logic                 r_negHi;
    logic                 r_divZero;
    logic [WIDTH-1:0]     r_dividend;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_isSigned;
    logic                 w_aNeg;
    logic                 w_bNeg;
    logic [WIDTH-1:0]     w_absA;
    logic [WIDTH-1:0]     w_absB;
    logic [WIDTH:0]       w_mulSum;
    logic [2*WIDTH-1:0]   w_mulNext;
    logic [WIDTH:0]       w_divShift;
    logic [WIDTH:0]       w_divDiff;
    logic [2*WIDTH-1:0]   w_divNext;
    logic [2*WIDTH-1:0]   w_step;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;
    logic [WIDTH-1:0]     w_fixHi;
    logic [WIDTH-1:0]     w_fixLo;

    // Signed ops iterate on magnitudes; the most negative value maps onto itself as an unsigned magnitude.
    assign w_isSigned = ~bus.op[0];
    assign w_aNeg     = w_isSigned & bus.rs_data[WIDTH-1];
    assign w_bNeg     = w_isSigned & bus.rt_data[WIDTH-1];
    assign w_absA     = w_aNeg ? -bus.rs_data : bus.rs_data;
    assign w_absB     = w_bNeg ? -bus.rt_data : bus.rt_data;

    // Multiply: the multiplier sits in the low half and is consumed LSB-first as the sum shifts in from the top.
    assign w_mulSum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_operand} : '0);
    assign w_mulNext  = {w_mulSum, r_acc[WIDTH-1:1]};

    // Divide: remainder in the high half, dividend shifting out of the low half as quotient bits shift in.
    assign w_divShift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_divDiff  = w_divShift - {1'b0, r_operand};
    assign w_divNext  = w_divDiff[WIDTH]
                      ? {w_divShift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                      : {w_divDiff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

    assign w_step     = r_isDiv ? w_divNext : w_mulNext;

    assign w_prod     = r_negLo ? -r_acc : r_acc;
    assign w_quo      = r_negLo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem      = r_negHi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    // A zero divisor bypasses the iteration result: quotient all ones, HI gets the untouched dividend.
    assign w_fixHi    = r_divZero ? r_dividend
                      : (r_isDiv ? w_rem : w_prod[2*WIDTH-1:WIDTH]);
    assign w_fixLo    = r_divZero ? {WIDTH{1'b1}}
                      : (r_isDiv ? w_quo : w_prod[WIDTH-1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_isDiv    <= 1'b0;
            r_operand  <= '0;
            r_acc      <= '0;
            r_negLo    <= 1'b0;
            r_negHi    <= 1'b0;
            r_divZero  <= 1'b0;
            r_dividend <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state    <= RUN;
                        r_busy     <= 1'b1;
                        r_count    <= CW'(WIDTH - 1);
                        r_isDiv    <= bus.op[1];
                        r_operand  <= bus.op[1] ? w_absB : w_absA;
                        r_acc      <= {{WIDTH{1'b0}}, (bus.op[1] ? w_absA : w_absB)};
                        r_negLo    <= w_aNeg ^ w_bNeg;
                        r_negHi    <= bus.op[1] ? w_aNeg : (w_aNeg ^ w_bNeg);
                        r_divZero  <= bus.op[1] & (bus.rt_data == '0);
                        r_dividend <= bus.rs_data;
                    end else begin
                        if (bus.mthi) r_hi <= bus.rs_data;
                        if (bus.mtlo) r_lo <= bus.rs_data;
                    end
                end
                RUN: begin
                    r_acc <= w_step;
                    if (r_count == '0) begin
                        r_state <= FIX;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                FIX: begin
                    r_hi    <= w_fixHi;
                    r_lo    <= w_fixLo;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized ops,
// all compared against a plain-arithmetic model of MIPS MULT/MULTU/DIV/DIVU and HI/LO moves.
module tb_muldiv_unit;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] modelHi = 32'h0;
    logic [31:0] modelLo = 32'h0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Returns {hi, lo} as the architecture defines them.
    function automatic logic [63:0] refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: res = sa * sb;
            2'd1: res = {32'h0, a} * {32'h0, b};
            2'd2: begin
                if (b == 32'h0) begin
                    res = {a, 32'hFFFFFFFF};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'h0) res = {a, 32'hFFFFFFFF};
                else            res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input bit disturb, input bit moveWithStart);
        logic [63:0] exp;
        int k, busyCycles, stale;
        exp = refModel(op, a, b);
        bus.op      = op;
        bus.rs_data = a;
        bus.rt_data = b;
        bus.start   = 1'b1;
        bus.mthi    = moveWithStart;
        bus.mtlo    = moveWithStart;
        tick();
        bus.start   = 1'b0;
        bus.mthi    = 1'b0;
        bus.mtlo    = 1'b0;
        bus.op      = ~op;
        bus.rs_data = $urandom;
        bus.rt_data = $urandom;
        k = 0;
        busyCycles = 0;
        stale = 0;
        while (!bus.done && k < 40) begin
            if (bus.busy) busyCycles++;
            if (bus.hi !== modelHi || bus.lo !== modelLo) stale++;
            if (disturb && k == 5) begin
                bus.start   = 1'b1;
                bus.mthi    = 1'b1;
                bus.mtlo    = 1'b1;
                bus.rs_data = 32'hDEADBEEF;
            end
            if (disturb && k == 6) begin
                bus.start = 1'b0;
                bus.mthi  = 1'b0;
                bus.mtlo  = 1'b0;
            end
            tick();
            k++;
        end
        checkOutput("latency", k, 33);
        checkOutput("busyCycles", busyCycles, 33);
        checkOutput("holdHiLo", stale, 0);
        checkOutput("busyAtDone", bus.busy, 1'b0);
        checkOutput("hi", bus.hi, exp[63:32]);
        checkOutput("lo", bus.lo, exp[31:0]);
        modelHi = exp[63:32];
        modelLo = exp[31:0];
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        int doneCount;

        bus.start   = 1'b0;
        bus.op      = 2'd0;
        bus.rs_data = 32'h0;
        bus.rt_data = 32'h0;
        bus.mthi    = 1'b0;
        bus.mtlo    = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        checkOutput("resetHi", bus.hi, 32'h0);
        checkOutput("resetLo", bus.lo, 32'h0);
        checkOutput("resetBusy", bus.busy, 1'b0);
        checkOutput("resetDone", bus.done, 1'b0);
        rst = 1'b0;

        applyStimulus(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        tick();
        checkOutput("doneOnePulse", bus.done, 1'b0);

        applyStimulus(2'd0, 32'hFFFFFFFD, 32'h00000007, 1'b0, 1'b0);
        applyStimulus(2'd2, 32'hFFFFFFF9, 32'h00000002, 1'b0, 1'b0);
        applyStimulus(2'd3, 32'd7, 32'd2, 1'b0, 1'b0);
        applyStimulus(2'd3, 32'h00001234, 32'h0, 1'b0, 1'b0);
        applyStimulus(2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        applyStimulus(2'd2, 32'hFFFFFF00, 32'h0, 1'b0, 1'b0);

        bus.rs_data = 32'hA5A5A5A5;
        bus.mtlo = 1'b1;
        tick();
        bus.mtlo = 1'b0;
        checkOutput("mtloLo", bus.lo, 32'hA5A5A5A5);
        checkOutput("mtloHi", bus.hi, modelHi);
        modelLo = 32'hA5A5A5A5;

        bus.rs_data = 32'h12345678;
        bus.mthi = 1'b1;
        bus.mtlo = 1'b1;
        tick();
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        checkOutput("mtBothHi", bus.hi, 32'h12345678);
        checkOutput("mtBothLo", bus.lo, 32'h12345678);
        modelHi = 32'h12345678;
        modelLo = 32'h12345678;

        applyStimulus(2'd0, 32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0);
        checkOutput("notDeadBeef", (bus.hi == 32'hDEADBEEF), 1'b0);
        applyStimulus(2'd1, 32'd3, 32'd5, 1'b0, 1'b1);

        bus.rs_data = 32'hCAFEF00D;
        bus.mthi = 1'b1;
        tick();
        bus.mthi = 1'b0;
        modelHi = 32'hCAFEF00D;

        bus.op      = 2'd1;
        bus.rs_data = 32'd5;
        bus.rt_data = 32'd6;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i <= 9; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abortBusy", bus.busy, 1'b0);
        checkOutput("abortHi", bus.hi, 32'h0);
        checkOutput("abortLo", bus.lo, 32'h0);
        checkOutput("abortDone", bus.done, 1'b0);
        modelHi = 32'h0;
        modelLo = 32'h0;
        doneCount = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) doneCount++;
            tick();
        end
        checkOutput("abortNoDone", doneCount, 0);
        applyStimulus(2'd1, 32'd5, 32'd6, 1'b0, 1'b0);

        applyStimulus(2'd3, 32'd100, 32'd7, 1'b0, 1'b0);
        applyStimulus(2'd1, 32'd3, 32'd4, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            if (i % 6 == 0)      rb = 32'h0;
            else if (i % 4 == 1) rb = 32'($urandom_range(1, 15));
            else                 rb = $urandom;
            applyStimulus(rop, ra, rb, 1'b0, 1'b0);
        end

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
